// File: rtl/lockstep_pkg.sv
// Shared constants for the CPU lockstep checker: FSM encodings, counter
// saturation value and the packed transaction width helper.
package lockstep_pkg;

    // FSM state encodings
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StHalted = 2'd2;

    // mismatch_count saturates here instead of wrapping
    localparam logic [15:0] MismatchSat = 16'hFFFF;

    // Packed transaction {we, addr, data} width for given bus widths
    function automatic int unsigned txn_width(input int unsigned addr_w,
                                              input int unsigned data_w);
        return addr_w + data_w + 1;
    endfunction

    // Width of a transaction with the default 16-bit address, 8-bit data bus
    localparam int unsigned DefaultTxnW = 25;

endpackage

// File: rtl/lockstep_fifo.sv
// Synchronous FIFO holding one side's bus transactions. Pointers carry one
// extra wrap bit so full and empty are exact without a separate count.
module lockstep_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en, rd_en;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !empty_o;
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    // Pointer next-state; clear wins over push/pop
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_en) wptr_d = wptr_q + (AW+1)'(1);
            if (rd_en) rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    // Pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; contents are don't-care while empty so it has no reset
    always_ff @(posedge clk_i) begin
        if (wr_en && !clear_i) begin
            mem_q[wptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/cpu_lockstep_checker.sv
// Lockstep checker: buffers the reference-model and DUV bus transaction
// streams independently and compares them in order, flagging mismatches,
// excessive skew and buffer overflow, and keeping the first failing pair.
module cpu_lockstep_checker
    import lockstep_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned MAX_SKEW = 64,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic                     stop_on_mismatch_i,
    input  logic                     ref_valid_i,
    input  logic [ADDR_W-1:0]        ref_addr_i,
    input  logic [DATA_W-1:0]        ref_data_i,
    input  logic                     ref_we_i,
    input  logic                     duv_valid_i,
    input  logic [ADDR_W-1:0]        duv_addr_i,
    input  logic [DATA_W-1:0]        duv_data_i,
    input  logic                     duv_we_i,
    output logic [CNT_W-1:0]         cmp_count_o,
    output logic [15:0]              mismatch_count_o,
    output logic                     err_mismatch_o,
    output logic                     err_timeout_o,
    output logic                     err_overflow_o,
    output logic                     halted_o,
    output logic [ADDR_W+DATA_W:0]   first_ref_o,
    output logic [ADDR_W+DATA_W:0]   first_duv_o
);

    localparam int unsigned  TxnW      = txn_width(ADDR_W, DATA_W);
    localparam logic [15:0]  SkewLimit = 16'(MAX_SKEW);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } txn_t;

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [15:0]     mm_q, mm_d;
    logic [15:0]     skew_q, skew_d;
    logic            err_mm_q, err_mm_d;
    logic            err_to_q, err_to_d;
    logic            err_ov_q, err_ov_d;
    logic [TxnW-1:0] first_ref_q, first_ref_d;
    logic [TxnW-1:0] first_duv_q, first_duv_d;

    txn_t            ref_txn, duv_txn;
    logic [TxnW-1:0] ref_head, duv_head;
    logic            ref_full, ref_empty, duv_full, duv_empty;
    logic            run, do_pop, ref_push, duv_push;
    logic            ovf, mismatch, timeout, one_sided;

    assign ref_txn.we   = ref_we_i;
    assign ref_txn.addr = ref_addr_i;
    assign ref_txn.data = ref_data_i;
    assign duv_txn.we   = duv_we_i;
    assign duv_txn.addr = duv_addr_i;
    assign duv_txn.data = duv_data_i;

    // Capture/compare only happens in RUN and never in a clearing cycle
    assign run       = (state_q == StRun) && !clear_i;
    assign do_pop    = run && !ref_empty && !duv_empty;
    assign ref_push  = run && ref_valid_i;
    assign duv_push  = run && duv_valid_i;
    assign ovf       = (ref_push && ref_full && !do_pop) || (duv_push && duv_full && !do_pop);
    assign mismatch  = do_pop && (ref_head != duv_head);
    assign one_sided = (ref_empty != duv_empty);
    assign timeout   = run && one_sided && ((skew_q + 16'd1) >= SkewLimit);

    lockstep_fifo #(
        .WIDTH (TxnW),
        .DEPTH (DEPTH)
    ) u_ref_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (ref_push),
        .pop_i   (do_pop),
        .din_i   (ref_txn),
        .dout_o  (ref_head),
        .full_o  (ref_full),
        .empty_o (ref_empty)
    );

    lockstep_fifo #(
        .WIDTH (TxnW),
        .DEPTH (DEPTH)
    ) u_duv_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (duv_push),
        .pop_i   (do_pop),
        .din_i   (duv_txn),
        .dout_o  (duv_head),
        .full_o  (duv_full),
        .empty_o (duv_empty)
    );

    // FSM, counters, sticky flags and first-failure capture
    always_comb begin
        state_d     = state_q;
        cmp_d       = cmp_q;
        mm_d        = mm_q;
        skew_d      = skew_q;
        err_mm_d    = err_mm_q;
        err_to_d    = err_to_q;
        err_ov_d    = err_ov_q;
        first_ref_d = first_ref_q;
        first_duv_d = first_duv_q;
        if (clear_i) begin
            state_d     = StIdle;
            cmp_d       = '0;
            mm_d        = '0;
            skew_d      = '0;
            err_mm_d    = 1'b0;
            err_to_d    = 1'b0;
            err_ov_d    = 1'b0;
            first_ref_d = '0;
            first_duv_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable_i) state_d = StRun;
                end
                StRun: begin
                    if (do_pop) cmp_d = cmp_q + CNT_W'(1);
                    if (mismatch) begin
                        if (mm_q != MismatchSat) mm_d = mm_q + 16'd1;
                        err_mm_d = 1'b1;
                        if (!err_mm_q) begin
                            first_ref_d = ref_head;
                            first_duv_d = duv_head;
                        end
                    end
                    if (ovf) err_ov_d = 1'b1;
                    if (timeout) err_to_d = 1'b1;
                    skew_d = one_sided ? skew_q + 16'd1 : 16'd0;
                    if (ovf || timeout || (mismatch && stop_on_mismatch_i)) begin
                        state_d = StHalted;
                    end else if (!enable_i) begin
                        state_d = StIdle;
                    end
                end
                StHalted: begin
                    state_d = StHalted;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cmp_q       <= '0;
            mm_q        <= '0;
            skew_q      <= '0;
            err_mm_q    <= 1'b0;
            err_to_q    <= 1'b0;
            err_ov_q    <= 1'b0;
            first_ref_q <= '0;
            first_duv_q <= '0;
        end else begin
            state_q     <= state_d;
            cmp_q       <= cmp_d;
            mm_q        <= mm_d;
            skew_q      <= skew_d;
            err_mm_q    <= err_mm_d;
            err_to_q    <= err_to_d;
            err_ov_q    <= err_ov_d;
            first_ref_q <= first_ref_d;
            first_duv_q <= first_duv_d;
        end
    end

    assign cmp_count_o      = cmp_q;
    assign mismatch_count_o = mm_q;
    assign err_mismatch_o   = err_mm_q;
    assign err_timeout_o    = err_to_q;
    assign err_overflow_o   = err_ov_q;
    assign halted_o         = (state_q == StHalted);
    assign first_ref_o      = first_ref_q;
    assign first_duv_o      = first_duv_q;

endmodule

// File: tb/tb_cpu_lockstep_checker.sv
// Directed bench for cpu_lockstep_checker. A default instance (MAX_SKEW=64)
// and a second instance with MAX_SKEW=10 share all inputs; the second is
// only inspected for the skew-timeout scenario.
module tb_cpu_lockstep_checker;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        enable_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        stop_on_mismatch_i = 1'b0;
    logic        ref_valid_i = 1'b0;
    logic [15:0] ref_addr_i = '0;
    logic [7:0]  ref_data_i = '0;
    logic        ref_we_i = 1'b0;
    logic        duv_valid_i = 1'b0;
    logic [15:0] duv_addr_i = '0;
    logic [7:0]  duv_data_i = '0;
    logic        duv_we_i = 1'b0;

    logic [31:0] cmp_count;
    logic [15:0] mismatch_count;
    logic        err_mismatch, err_timeout, err_overflow, halted;
    logic [24:0] first_ref, first_duv;

    logic [31:0] cmp_count_t;
    logic [15:0] mismatch_count_t;
    logic        err_mismatch_t, err_timeout_t, err_overflow_t, halted_t;
    logic [24:0] first_ref_t, first_duv_t;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    cpu_lockstep_checker dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .enable_i           (enable_i),
        .clear_i            (clear_i),
        .stop_on_mismatch_i (stop_on_mismatch_i),
        .ref_valid_i        (ref_valid_i),
        .ref_addr_i         (ref_addr_i),
        .ref_data_i         (ref_data_i),
        .ref_we_i           (ref_we_i),
        .duv_valid_i        (duv_valid_i),
        .duv_addr_i         (duv_addr_i),
        .duv_data_i         (duv_data_i),
        .duv_we_i           (duv_we_i),
        .cmp_count_o        (cmp_count),
        .mismatch_count_o   (mismatch_count),
        .err_mismatch_o     (err_mismatch),
        .err_timeout_o      (err_timeout),
        .err_overflow_o     (err_overflow),
        .halted_o           (halted),
        .first_ref_o        (first_ref),
        .first_duv_o        (first_duv)
    );

    cpu_lockstep_checker #(
        .MAX_SKEW (10)
    ) dut_t (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .enable_i           (enable_i),
        .clear_i            (clear_i),
        .stop_on_mismatch_i (stop_on_mismatch_i),
        .ref_valid_i        (ref_valid_i),
        .ref_addr_i         (ref_addr_i),
        .ref_data_i         (ref_data_i),
        .ref_we_i           (ref_we_i),
        .duv_valid_i        (duv_valid_i),
        .duv_addr_i         (duv_addr_i),
        .duv_data_i         (duv_data_i),
        .duv_we_i           (duv_we_i),
        .cmp_count_o        (cmp_count_t),
        .mismatch_count_o   (mismatch_count_t),
        .err_mismatch_o     (err_mismatch_t),
        .err_timeout_o      (err_timeout_t),
        .err_overflow_o     (err_overflow_t),
        .halted_o           (halted_t),
        .first_ref_o        (first_ref_t),
        .first_duv_o        (first_duv_t)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_bus();
        ref_valid_i = 1'b0;
        duv_valid_i = 1'b0;
    endtask

    task automatic drive_ref(input logic v, input logic we, input logic [15:0] a,
                             input logic [7:0] d);
        ref_valid_i = v;
        ref_we_i    = we;
        ref_addr_i  = a;
        ref_data_i  = d;
    endtask

    task automatic drive_duv(input logic v, input logic we, input logic [15:0] a,
                             input logic [7:0] d);
        duv_valid_i = v;
        duv_we_i    = we;
        duv_addr_i  = a;
        duv_data_i  = d;
    endtask

    task automatic do_clear();
        idle_bus();
        enable_i = 1'b0;
        clear_i  = 1'b1;
        step();
        clear_i  = 1'b0;
    endtask

    // Clear, then enable and wait for the IDLE->RUN edge
    task automatic start_run(input logic stop);
        do_clear();
        stop_on_mismatch_i = stop;
        enable_i = 1'b1;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " cmp"}, 64'(cmp_count), 64'd0);
        check({tag, " mm"}, 64'(mismatch_count), 64'd0);
        check({tag, " flags"}, 64'({err_mismatch, err_timeout, err_overflow, halted}), 64'd0);
        check({tag, " first"}, 64'({first_ref, first_duv}), 64'd0);
    endtask

    initial begin
        // Reset state
        #2;
        check_all_zero("reset");
        #10;
        rst_ni = 1'b1;
        step();

        // Identical streams, 100 pairs in the same cycles
        start_run(1'b0);
        for (int i = 0; i < 100; i++) begin
            drive_ref(1'b1, i[0], 16'(i * 7), 8'(i * 3));
            drive_duv(1'b1, i[0], 16'(i * 7), 8'(i * 3));
            step();
            // pair j lands on edge j and is compared on edge j+1
            if (i == 0) check("lat first push", 64'(cmp_count), 64'd0);
            if (i == 1) check("lat second push", 64'(cmp_count), 64'd1);
            if (i == 50) check("lat mid stream", 64'(cmp_count), 64'd50);
        end
        idle_bus();
        step();
        step();
        check("ident cmp", 64'(cmp_count), 64'd100);
        check("ident mm", 64'(mismatch_count), 64'd0);
        check("ident flags", 64'({err_mismatch, err_timeout, err_overflow, halted}), 64'd0);

        // DUV lags by 5 cycles over 20 transactions
        start_run(1'b0);
        for (int c = 0; c < 25; c++) begin
            drive_ref(c < 20, 1'b1, 16'h2000 + 16'(c), 8'(c + 8'h40));
            drive_duv(c >= 5, 1'b1, 16'h2000 + 16'(c - 5), 8'(c - 5 + 8'h40));
            step();
        end
        idle_bus();
        step();
        step();
        check("skew cmp", 64'(cmp_count), 64'd20);
        check("skew flags", 64'({err_mismatch, err_timeout, err_overflow, halted}), 64'd0);
        check("skew10 flags", 64'({err_timeout_t, halted_t}), 64'd0);

        // 7th pair differs in data, stop_on_mismatch set
        start_run(1'b1);
        for (int i = 0; i < 10; i++) begin
            drive_ref(1'b1, 1'b0, 16'h1000 + 16'(i), (i == 6) ? 8'h3C : 8'(i + 8'h10));
            drive_duv(1'b1, 1'b0, 16'h1000 + 16'(i), (i == 6) ? 8'h3D : 8'(i + 8'h10));
            step();
        end
        idle_bus();
        step();
        step();
        check("mm err", 64'(err_mismatch), 64'd1);
        check("mm count", 64'(mismatch_count), 64'd1);
        check("mm halted", 64'(halted), 64'd1);
        check("mm cmp", 64'(cmp_count), 64'd7);
        check("mm first_ref", 64'(first_ref), 64'({1'b0, 16'h1006, 8'h3C}));
        check("mm first_duv", 64'(first_duv), 64'({1'b0, 16'h1006, 8'h3D}));
        check("mm other flags", 64'({err_timeout, err_overflow}), 64'd0);

        // Clear out of HALTED with entries still buffered
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check_all_zero("clear halted");

        // Timeout on the MAX_SKEW=10 instance: one ref entry, DUV silent
        start_run(1'b0);
        drive_ref(1'b1, 1'b1, 16'hBEEF, 8'h55);
        step();
        idle_bus();
        for (int k = 0; k < 9; k++) step();
        check("to before limit", 64'({err_timeout_t, halted_t}), 64'd0);
        step();
        check("to at limit", 64'({err_timeout_t, halted_t}), 64'b11);
        check("to default inst", 64'({err_timeout, halted}), 64'd0);

        // Overflow: 9 ref pushes into an 8-deep buffer, DUV silent
        start_run(1'b0);
        for (int i = 0; i < 9; i++) begin
            drive_ref(1'b1, 1'b0, 16'h3000 + 16'(i), 8'(i));
            step();
            if (i == 7) check("ovf after 8", 64'({err_overflow, halted}), 64'd0);
        end
        idle_bus();
        check("ovf after 9", 64'({err_overflow, halted}), 64'b11);
        check("ovf cmp", 64'(cmp_count), 64'd0);

        // Clear must also drop the eight buffered ref entries
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check_all_zero("clear ovf");
        enable_i = 1'b1;
        step();
        drive_ref(1'b1, 1'b1, 16'hA5A5, 8'hE1);
        drive_duv(1'b1, 1'b1, 16'hA5A5, 8'hE1);
        step();
        idle_bus();
        step();
        check("post clear cmp", 64'(cmp_count), 64'd1);
        check("post clear mm", 64'(mismatch_count), 64'd0);

        // Asynchronous reset mid-compare
        start_run(1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_ref(1'b1, 1'b0, 16'(i), 8'(i));
            drive_duv(1'b1, 1'b0, 16'(i), 8'(i));
            step();
        end
        check("pre reset cmp", 64'(cmp_count), 64'd3);
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_zero("async reset");
        idle_bus();
        #3;
        rst_ni = 1'b1;
        step();
        check_all_zero("after reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_lockstep_checker.md
Name: cpu_lockstep_checker

Overview:
- Parametrised lockstep checker that compares the CPU bus transaction streams of the reference model and the design under verification.
- Sits beside the reference-model and DUV CPU instances. Taps each CPU's bus strobes, buffers each stream so the two CPUs may drift apart by a bounded number of cycles, and compares them in order.
- Reports mismatches, skew timeouts and buffer overflow. Keeps the first failing pair of transactions for debug.
- Synthesizable, so it can also run on an FPGA alongside the two cores.

Parameters:
- ADDR_W, 16, bus address width.
- DATA_W, 8, bus data width.
- DEPTH, 8, per-side transaction buffer entries; must be a power of two, at least 2.
- MAX_SKEW, 64, cycles one side may lead the other before a timeout; range 1..65535.
- CNT_W, 32, width of the compare counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  capture and compare enable.
- clear  in  1  synchronous clear of buffers, counters, flags and state.
- stop_on_mismatch  in  1  when high, the first mismatch halts checking.
- ref_valid  in  1  reference-model bus transaction strobe.
- ref_addr  in  ADDR_W  reference-model bus address.
- ref_data  in  DATA_W  reference-model bus data (read or write).
- ref_we  in  1  reference-model write enable.
- duv_valid  in  1  DUV bus transaction strobe.
- duv_addr  in  ADDR_W  DUV bus address.
- duv_data  in  DATA_W  DUV bus data (read or write).
- duv_we  in  1  DUV write enable.
- cmp_count  out  CNT_W  number of transaction pairs compared.
- mismatch_count  out  16  number of mismatching pairs.
- err_mismatch  out  1  sticky; at least one mismatch has occurred.
- err_timeout  out  1  sticky; skew limit exceeded.
- err_overflow  out  1  sticky; a transaction was lost to a full buffer.
- halted  out  1  high while in HALTED.
- first_ref  out  ADDR_W+DATA_W+1  first mismatching reference transaction, packed as {we, addr, data}.
- first_duv  out  ADDR_W+DATA_W+1  first mismatching DUV transaction, packed as {we, addr, data}.

Behaviour:
Reset and clear
- Reset (rst_n low, asynchronous): every output is 0, both buffers are empty, the skew counter is 0, state is IDLE.
- clear high: same effect as reset, applied at the next clk edge. clear has priority over every other event in that cycle.

State machine (IDLE, RUN, HALTED)
- IDLE -> RUN when enable=1.
- RUN -> IDLE when enable=0. Buffer contents are kept; nothing is pushed or popped while in IDLE.
- RUN -> HALTED on any of:
  - overflow;
  - timeout;
  - mismatch while stop_on_mismatch=1.
- HALTED is left only through clear or reset. In HALTED, counters and captured data are frozen.

Capture
- In RUN, ref_valid=1 pushes {ref_we, ref_addr, ref_data} into the ref buffer; duv_valid likewise pushes into the duv buffer. The two sides are independent.

Compare
- In RUN, when both buffers are non-empty, the two head entries are popped together and compared on all fields.
- Minimum latency: strobes in cycle N, compare in cycle N+1, counters and flags visible after the N+1 edge.
- On every compare, cmp_count increments. It wraps modulo 2^CNT_W.
- On a mismatch:
  - mismatch_count increments and saturates at 0xFFFF;
  - err_mismatch is set;
  - first_ref and first_duv are loaded only if err_mismatch was 0 before this compare.

Buffer boundary conditions
- A push to a full buffer is accepted if that buffer is popped in the same cycle.
- Otherwise the push is dropped, err_overflow is set, and the state goes to HALTED.
- Push and pop on an empty buffer in the same cycle: the entry is not compared until the next cycle (no bypass).
- Pointers are log2(DEPTH)+1 bits wide, giving exact full and empty detection across wrap-around.

Skew counter
- In RUN, counts every cycle in which exactly one buffer is non-empty.
- Resets to 0 when both buffers are empty or both are non-empty.
- Reaching MAX_SKEW sets err_timeout and the state goes to HALTED.

Simultaneous events
- Overflow, timeout and mismatch in the same cycle: all applicable flags are set; a single transition to HALTED.

Decomposition:
- Package lockstep_pkg holds:
  - the state enum (IDLE, RUN, HALTED);
  - the parametrised transaction struct {we, addr, data}, which needs ADDR_W and DATA_W, so it is a typedef in the module with a matching pack width constant in the package;
  - the counter saturation constant 16'hFFFF.
- One sub-module: lockstep_fifo, a synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Async active-low reset plus synchronous clear.
  - Instantiated twice, once per side.

Test Plan:
- Identical streams: enable=1; 100 identical pairs at the same cycle -> cmp_count=100, mismatch_count=0, all error flags 0.
- Skewed streams: DUV lags by 5 cycles over 20 transactions, MAX_SKEW=64 -> cmp_count=20, no errors; skew counter peaks at 5.
- Single mismatch: the 7th pair differs in data (ref 8'h3C, duv 8'h3D) with stop_on_mismatch=1 -> err_mismatch=1, mismatch_count=1, first_ref and first_duv hold the 7th entries, halted=1, cmp_count=7, later pairs ignored.
- Timeout: ref issues 1 transaction, DUV is silent, MAX_SKEW=10 -> err_timeout=1 and halted=1 exactly 10 cycles after the entry lands in the buffer.
- Overflow: DEPTH=8; ref pushes 9 transactions with no DUV activity -> err_overflow=1 on the 9th push, halted=1, cmp_count=0.
- Reset and clear mid-run: assert clear while in HALTED with entries buffered -> all outputs 0 and state IDLE next cycle; assert rst_n low asynchronously mid-compare -> outputs 0 immediately.
